// File: rtl/c17_response_misr.sv
// ---------------------------------------------------------------------------
// c17_response_misr
//
// Purpose:
//   This block compacts the responses from the 8-bit shift-register / c17
//   combined block. On each accepted cycle it folds the 11 observable outputs
//   into a multiple-input signature register (MISR). After the programmed
//   number of valid samples, it compares the signature with a golden value
//   and gives a single pass/fail verdict.
//
// Parameters:
//   CNT_W        width of the pattern counter and of num_patterns
//   POLY         MISR feedback taps; the x^11 term is implicit
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-low reset (0 = asserted)
//   start        begins a compaction run (honoured in IDLE or DONE only)
//   num_patterns number of valid samples to compact, latched on start
//   golden       expected signature, latched on start
//   din_valid    the current sample is valid
//   shiftout_in  shift-register outputs of the upstream block
//   n22/n23/n24  c17 outputs of the upstream block
//   busy         high while compacting
//   done         high once the run has finished
//   pass         signature matched golden (meaningful while done is high)
//   signature    current MISR contents
// ---------------------------------------------------------------------------
module c17_response_misr #(
  parameter int          CNT_W = 8,
  parameter logic [10:0] POLY  = 11'h005
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [10:0]      golden,
  input  logic             din_valid,
  input  logic [7:0]       shiftout_in,
  input  logic             n22,
  input  logic             n23,
  input  logic             n24,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [10:0]      signature
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } stateT;

  stateT            r_state;
  logic [10:0]      r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_numPat;
  logic [10:0]      r_golden;
  logic             r_pass;

  stateT            w_stateNext;
  logic [10:0]      w_sigNext;
  logic [CNT_W-1:0] w_cntNext;
  logic [CNT_W-1:0] w_numPatNext;
  logic [10:0]      w_goldenNext;
  logic             w_passNext;
  logic [10:0]      w_sample;
  logic [10:0]      w_sigStep;

  // Shift-register outputs sit in the upper bits, and n24 is the LSB.
  assign w_sample = {shiftout_in, n22, n23, n24};

  // This is one MISR step. Bit 10 falls off the top and, when set, feeds
  // back through the tap polynomial.
  assign w_sigStep = {r_sig[9:0], 1'b0} ^ (r_sig[10] ? POLY : 11'h000) ^ w_sample;

  // All state is registered here. Reset clears the latched run setup as well
  // as the signature, so a run aborted mid-way leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_sig    <= '0;
      r_cnt    <= '0;
      r_numPat <= '0;
      r_golden <= '0;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_sig    <= w_sigNext;
      r_cnt    <= w_cntNext;
      r_numPat <= w_numPatNext;
      r_golden <= w_goldenNext;
      r_pass   <= w_passNext;
    end
  end

  // This block decides the next state and the datapath updates. A start
  // request is only honoured outside COMPACT. A zero-length run goes
  // straight to DONE with the verdict computed against an all-zero
  // signature. During COMPACT, the verdict is taken from the
  // post-update signature, so done and pass appear on the same edge.
  always_comb begin
    w_stateNext  = r_state;
    w_sigNext    = r_sig;
    w_cntNext    = r_cnt;
    w_numPatNext = r_numPat;
    w_goldenNext = r_golden;
    w_passNext   = r_pass;

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_sigNext    = '0;
          w_cntNext    = '0;
          w_numPatNext = num_patterns;
          w_goldenNext = golden;
          if (num_patterns == '0) begin
            w_stateNext = DONE;
            w_passNext  = (golden == 11'h000);
          end else begin
            w_stateNext = COMPACT;
            w_passNext  = 1'b0;
          end
        end
      end
      COMPACT: begin
        if (din_valid) begin
          w_sigNext = w_sigStep;
          w_cntNext = r_cnt + CNT_W'(1);
          if (r_cnt == r_numPat - CNT_W'(1)) begin
            w_stateNext = DONE;
            w_passNext  = (w_sigStep == r_golden);
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  assign busy      = (r_state == COMPACT);
  assign done      = (r_state == DONE);
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_c17_response_misr.sv
// ---------------------------------------------------------------------------
// tb_c17_response_misr
//
// Purpose:
//   This is a self-checking bench for c17_response_misr. It runs directed
//   scenarios followed by randomized runs. The expected results come from a
//   behavioural model. The model treats the signature as a polynomial over
//   GF(2): it multiplies by x, reduces modulo x^11 + POLY, and adds the
//   sample.
//
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_c17_response_misr;

  localparam int CNT_W = 8;
  localparam int POLY  = 'h005;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_patterns;
  logic [10:0]      golden;
  logic             din_valid;
  logic [7:0]       shiftout_in;
  logic             n22;
  logic             n23;
  logic             n24;
  logic             busy;
  logic             done;
  logic             pass;
  logic [10:0]      signature;

  int checkCount = 0;
  int errorCount = 0;

  // Model state.
  bit mRunning;
  bit mDone;
  bit mPass;
  int mSig;
  int mCnt;
  int mNum;
  int mGold;

  c17_response_misr #(.CNT_W(CNT_W), .POLY(11'h005)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_patterns (num_patterns),
    .golden       (golden),
    .din_valid    (din_valid),
    .shiftout_in  (shiftout_in),
    .n22          (n22),
    .n23          (n23),
    .n24          (n24),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // This is the single comparison point. It counts every check and reports
  // any mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Signature update viewed as polynomial arithmetic: multiply by x, and
  // reduce an x^11 term into x^2+1. Then add the sample.
  function automatic int misrNext(input int sig, input int d);
    int t;
    t = sig * 2;
    if (t >= 2048) t = (t - 2048) ^ POLY;
    return t ^ d;
  endfunction

  // This task applies the behavioural rules of the block for one clock.
  task automatic modelStep(input bit st, input int np, input int gold, input bit dv, input int d);
    if (!mRunning && st) begin
      mSig = 0;
      mCnt = 0;
      mNum = np;
      mGold = gold;
      if (np == 0) begin
        mDone = 1'b1;
        mPass = (gold == 0);
      end else begin
        mRunning = 1'b1;
        mDone = 1'b0;
        mPass = 1'b0;
      end
    end else if (mRunning && dv) begin
      mSig = misrNext(mSig, d);
      mCnt++;
      if (mCnt == mNum) begin
        mRunning = 1'b0;
        mDone = 1'b1;
        mPass = (mSig == mGold);
      end
    end
  endtask

  task automatic modelReset();
    mRunning = 1'b0;
    mDone = 1'b0;
    mPass = 1'b0;
    mSig = 0;
    mCnt = 0;
    mNum = 0;
    mGold = 0;
  endtask

  // This task drives one cycle of inputs, advances the model, waits for the
  // edge, and compares every output with the model shortly after the edge.
  task automatic applyStimulus(input bit st, input int np, input int gold,
                               input bit dv, input int d);
    logic [10:0] dw;
    dw = d[10:0];
    start = st;
    num_patterns = np[CNT_W-1:0];
    golden = gold[10:0];
    din_valid = dv;
    shiftout_in = dw[10:3];
    n22 = dw[2];
    n23 = dw[1];
    n24 = dw[0];
    modelStep(st, np, gold, dv, d);
    @(posedge clk);
    #1;
    checkOutput("busy", busy, mRunning);
    checkOutput("done", done, mDone);
    checkOutput("signature", signature, mSig);
    if (mDone) checkOutput("pass", pass, mPass);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 0, 0, 1'b0, $urandom_range(0, 2047));
  endtask

  // These are the randomized runs. The samples are pre-generated, so the
  // golden value can be set to the correct signature about half the time.
  task automatic randomRun();
    int np;
    int samples[$];
    int predicted;
    int gold;
    int taken;
    int guard;
    np = $urandom_range(0, 7);
    predicted = 0;
    for (int i = 0; i < np; i++) begin
      samples.push_back($urandom_range(0, 2047));
      predicted = misrNext(predicted, samples[i]);
    end
    gold = $urandom_range(0, 1) ? predicted : $urandom_range(0, 2047);
    applyStimulus(1'b1, np, gold, 1'b0, 0);
    taken = 0;
    guard = 0;
    while (taken < np && guard < 100) begin
      if ($urandom_range(0, 9) < 7) begin
        applyStimulus($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 2047),
                      1'b1, samples[taken]);
        taken++;
      end else begin
        applyStimulus(1'b0, 0, 0, 1'b0, $urandom_range(0, 2047));
      end
      guard++;
    end
    checkOutput("rand_guard", int'(guard < 100), 1);
    checkOutput("rand_sig", signature, predicted);
    checkOutput("rand_pass", pass, int'(gold == predicted));
    idleCycle();
  endtask

  initial begin
    start = 1'b0;
    num_patterns = '0;
    golden = '0;
    din_valid = 1'b0;
    shiftout_in = '0;
    n22 = 1'b0;
    n23 = 1'b0;
    n24 = 1'b0;
    reset = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_sig", signature, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single pattern.
    applyStimulus(1'b1, 1, 'h7FF, 1'b0, 0);
    checkOutput("single_busy", busy, 1);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h7FF);
    checkOutput("single_sig", signature, 'h7FF);
    checkOutput("single_done", done, 1);
    checkOutput("single_pass", pass, 1);
    checkOutput("single_busy_off", busy, 0);

    // Feedback tap, with both the matching and the non-matching golden.
    applyStimulus(1'b1, 2, 'h005, 1'b0, 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h400);
    checkOutput("tap_sig1", signature, 'h400);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h000);
    checkOutput("tap_sig2", signature, 'h005);
    checkOutput("tap_pass", pass, 1);
    applyStimulus(1'b1, 2, 'h004, 1'b0, 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h400);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h000);
    checkOutput("tap_fail_sig", signature, 'h005);
    checkOutput("tap_fail_pass", pass, 0);
    checkOutput("tap_fail_done", done, 1);

    // Stall handling: invalid cycles with toggling data must be ignored.
    applyStimulus(1'b1, 2, 'h003, 1'b0, 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h001);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 0, 0, 1'b0, (i % 2) ? 'h7FF : 'h2AA);
      checkOutput("stall_done", done, 0);
    end
    applyStimulus(1'b0, 0, 0, 1'b1, 'h001);
    checkOutput("stall_sig", signature, 'h003);
    checkOutput("stall_done_end", done, 1);

    // Zero count, then din_valid pulses in DONE.
    applyStimulus(1'b1, 0, 'h000, 1'b0, 0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_pass", pass, 1);
    checkOutput("zero_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 0, 0, 1'b1, 'h5A5);
      checkOutput("done_dv_sig", signature, 0);
    end
    applyStimulus(1'b1, 0, 'h001, 1'b0, 0);
    checkOutput("zero_fail_pass", pass, 0);

    // Start during COMPACT must not restart the run.
    applyStimulus(1'b1, 3, 'h000, 1'b0, 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h001);
    applyStimulus(1'b1, 1, 'h000, 1'b1, 'h002);
    checkOutput("ign_start_busy", busy, 1);
    checkOutput("ign_start_sig", signature, 'h000);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h004);
    checkOutput("ign_start_done", done, 1);
    checkOutput("ign_start_sig2", signature, 'h004);

    // Restart from DONE.
    applyStimulus(1'b1, 1, 'h123, 1'b0, 0);
    checkOutput("restart_done", done, 0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_sig0", signature, 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h123);
    checkOutput("restart_sig", signature, 'h123);
    checkOutput("restart_pass", pass, 1);

    // Reset mid-run, applied away from the clock edge.
    applyStimulus(1'b1, 5, 'h000, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b1, 'h400 >> i);
    checkOutput("prerst_busy", busy, 1);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_pass", pass, 0);
    checkOutput("midrst_sig", signature, 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 2, 'h00C, 1'b0, 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h006);
    applyStimulus(1'b0, 0, 0, 1'b1, 'h000);
    checkOutput("postrst_sig", signature, 'h00C);
    checkOutput("postrst_pass", pass, 1);

    // Randomized runs against the model.
    for (int r = 0; r < 30; r++) randomRun();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  // This is a global watchdog, so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
